// File: rtl/viterbi_pkg.sv
// rtl/viterbi_pkg.sv - shared defaults, types and FSM encoding for the Viterbi traceback unit
package viterbi_pkg;

  localparam int DEF_NUM_STATE = 4;
  localparam int DEF_FRAME_LEN = 8;
  localparam int DEF_M         = $clog2(DEF_NUM_STATE);

  typedef logic [DEF_M-1:0]         state_t;
  typedef logic [DEF_NUM_STATE-1:0] dec_t;

  typedef enum logic [1:0] {
    WRITE,
    TRACE,
    OUTPUT
  } tb_fsm_e;

endpackage

// File: rtl/tb_survivor_mem.sv
// rtl/tb_survivor_mem.sv - one frame of per-state survivor decisions, sync write / comb read
module tb_survivor_mem
  import viterbi_pkg::*;
#(
  parameter int NUM_STATE = DEF_NUM_STATE,
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  localparam int AW = $clog2(FRAME_LEN)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_wr_en,
  input  logic [AW-1:0]        i_wr_addr,
  input  logic [NUM_STATE-1:0] i_wr_data,
  input  logic [AW-1:0]        i_rd_addr,
  output logic [NUM_STATE-1:0] o_rd_data
);

  logic [NUM_STATE-1:0] mem [FRAME_LEN];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < FRAME_LEN; i++) begin
        mem[i] <= '0;
      end
    end else if (i_wr_en) begin
      mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = mem[i_rd_addr];

endmodule

// File: rtl/viterbi_traceback.sv
// rtl/viterbi_traceback.sv - traceback from best final state, serial decoded bits oldest first
// Optional sticky o_overflow (vector offered while not ready) when VITERBI_TB_OVF_EN is defined.
module viterbi_traceback
  import viterbi_pkg::*;
#(
  parameter int NUM_STATE = DEF_NUM_STATE,
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  localparam int M  = $clog2(NUM_STATE),
  localparam int PW = $clog2(FRAME_LEN)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_dec_valid,
  input  logic [NUM_STATE-1:0] i_dec,
  input  logic [M-1:0]         i_best_state,
  output logic                 o_ready,
  output logic                 o_valid,
  output logic                 o_bit,
  output logic                 o_busy
`ifdef VITERBI_TB_OVF_EN
  ,
  output logic                 o_overflow
`endif
);

  localparam logic [PW-1:0] LAST_PTR = PW'(FRAME_LEN - 1);

  tb_fsm_e              state_q, state_d;
  logic [PW-1:0]        wr_ptr, tb_ptr, rd_ptr;
  logic [M-1:0]         tb_state, tb_pred;
  logic [FRAME_LEN-1:0] bitbuf;
  logic                 last_bit;
  logic                 mem_wr_en;
  logic                 pred_bit;
  logic [NUM_STATE-1:0] rd_data;

  tb_survivor_mem #(
    .NUM_STATE(NUM_STATE),
    .FRAME_LEN(FRAME_LEN)
  ) u_mem (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_wr_en  (mem_wr_en),
    .i_wr_addr(wr_ptr),
    .i_wr_data(i_dec),
    .i_rd_addr(tb_ptr),
    .o_rd_data(rd_data)
  );

  // The bit shifted out of the state register is recovered from the survivor decision.
  assign pred_bit = rd_data[tb_state];

  generate
    if (M > 1) begin : g_pred_shift
      assign tb_pred = {tb_state[M-2:0], pred_bit};
    end else begin : g_pred_single
      assign tb_pred = pred_bit;
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= WRITE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    o_ready   = 1'b0;
    o_valid   = 1'b0;
    o_busy    = 1'b0;
    mem_wr_en = 1'b0;
    unique case (state_q)
      WRITE: begin
        o_ready   = 1'b1;
        mem_wr_en = i_dec_valid;
        if (i_dec_valid && (wr_ptr == LAST_PTR)) begin
          state_d = TRACE;
        end
      end
      TRACE: begin
        o_busy = 1'b1;
        if (tb_ptr == '0) begin
          state_d = OUTPUT;
        end
      end
      OUTPUT: begin
        o_busy  = 1'b1;
        o_valid = 1'b1;
        if (rd_ptr == LAST_PTR) begin
          state_d = WRITE;
        end
      end
      default: state_d = WRITE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr   <= '0;
      tb_ptr   <= '0;
      rd_ptr   <= '0;
      tb_state <= '0;
      bitbuf   <= '0;
      last_bit <= 1'b0;
    end else begin
      unique case (state_q)
        WRITE: begin
          if (i_dec_valid) begin
            if (wr_ptr == LAST_PTR) begin
              wr_ptr   <= '0;
              tb_state <= i_best_state;
              tb_ptr   <= LAST_PTR;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
            end
          end
        end
        TRACE: begin
          bitbuf[tb_ptr] <= tb_state[M-1];
          tb_state       <= tb_pred;
          if (tb_ptr == '0) begin
            rd_ptr <= '0;
          end else begin
            tb_ptr <= tb_ptr - 1'b1;
          end
        end
        OUTPUT: begin
          last_bit <= bitbuf[rd_ptr];
          if (rd_ptr == LAST_PTR) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
          end else begin
            rd_ptr <= rd_ptr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Between frames the line keeps the last emitted bit rather than dropping to 0.
  assign o_bit = o_valid ? bitbuf[rd_ptr] : last_bit;

`ifdef VITERBI_TB_OVF_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_overflow <= 1'b0;
    end else if (i_dec_valid && !o_ready) begin
      o_overflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_viterbi_traceback.sv
// tb/tb_viterbi_traceback.sv - randomized self-checking bench for viterbi_traceback
// Checks o_overflow only when VITERBI_TB_OVF_EN is defined.
module tb_viterbi_traceback;
  import viterbi_pkg::*;

  localparam int NS = DEF_NUM_STATE;
  localparam int FL = DEF_FRAME_LEN;
  localparam int M  = DEF_M;

  logic   clk = 1'b0;
  logic   rst = 1'b0;
  logic   dec_valid = 1'b0;
  dec_t   dec = '0;
  state_t best = '0;
  logic   ready, valid, bitv, busy;
`ifdef VITERBI_TB_OVF_EN
  logic   ovf;
`endif

  int checks = 0;
  int failures = 0;

  dec_t          frame_dec [FL];
  state_t        frame_best;
  logic [FL-1:0] frame_u;

  viterbi_traceback #(
    .NUM_STATE(NS),
    .FRAME_LEN(FL)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_dec_valid (dec_valid),
    .i_dec       (dec),
    .i_best_state(best),
    .o_ready     (ready),
    .o_valid     (valid),
    .o_bit       (bitv),
    .o_busy      (busy)
`ifdef VITERBI_TB_OVF_EN
    ,
    .o_overflow  (ovf)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Encoder-side model: state s_t holds u_t..u_{t-M+1}, newest in MSB; the survivor
  // decision at s_t is the bit that falls off, u_{t-M}. hist[M-k] is u_{-k}.
  task automatic gen_frame(input logic [FL-1:0] u, input logic [M-1:0] hist, input bit noisy);
    logic [FL+M-1:0] seq;
    state_t s;
    dec_t d;
    seq = {u, hist};
    for (int t = 0; t < FL; t++) begin
      for (int k = 0; k < M; k++) s[M-1-k] = seq[M+t-k];
      d = noisy ? dec_t'($urandom) : '0;
      d[s] = seq[t];
      frame_dec[t] = d;
      if (t == FL - 1) frame_best = s;
    end
    frame_u = u;
  endtask

  task automatic send_frame(input bit gaps);
    for (int t = 0; t < FL; t++) begin
      @(negedge clk);
      dec_valid = 1'b1;
      dec       = frame_dec[t];
      best      = (t == FL - 1) ? frame_best : state_t'($urandom);
      if (gaps && t < FL - 1) begin
        @(negedge clk);
        dec_valid = 1'b0;
        dec       = dec_t'($urandom);
      end
    end
    @(negedge clk);
    dec_valid = 1'b0;
  endtask

  // Called at the first negedge after the last write (cycle 1).
  task automatic collect(output int lat, output logic [FL-1:0] bits, output int nv,
                         output logic rdy_after, output logic hold_bit);
    int c;
    c = 1; lat = -1; nv = 0; bits = '0;
    while (!valid && c < 100) begin
      @(negedge clk);
      c++;
    end
    if (valid) lat = c;
    while (valid && nv < 2 * FL) begin
      if (nv < FL) bits[nv] = bitv;
      nv++;
      @(negedge clk);
    end
    rdy_after = ready;
    hold_bit  = bitv;
  endtask

  task automatic count_valid(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (valid) n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    dec_valid = 1'b0;
    @(negedge clk);
    checks += 4;
    if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
    if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
    if (bitv !== 1'b0) begin failures++; $display("FAIL reset_bit got=%b exp=0", bitv); end
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
`ifdef VITERBI_TB_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
`endif
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_frame(input string name, input logic [FL-1:0] u, input logic [M-1:0] hist,
                            input bit noisy, input bit gaps);
    int lat, nv;
    logic [FL-1:0] bits;
    logic rdy, hold;
    gen_frame(u, hist, noisy);
    send_frame(gaps);
    collect(lat, bits, nv, rdy, hold);
    checks += 5;
    if (lat !== FL + 1) begin failures++; $display("FAIL %s_latency got=%0d exp=%0d", name, lat, FL + 1); end
    if (nv !== FL) begin failures++; $display("FAIL %s_valid_len got=%0d exp=%0d", name, nv, FL); end
    if (bits !== frame_u) begin failures++; $display("FAIL %s_bits got=%b exp=%b (LSB first)", name, bits, frame_u); end
    if (rdy !== 1'b1) begin failures++; $display("FAIL %s_ready_after got=%b exp=1", name, rdy); end
    if (hold !== frame_u[FL-1]) begin failures++; $display("FAIL %s_bit_hold got=%b exp=%b", name, hold, frame_u[FL-1]); end
  endtask

  task automatic test_zero_frame;
    test_frame("zero", '0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_known_pattern;
    test_frame("pattern", 8'b0100_1101, '0, 1'b0, 1'b0);
  endtask

  task automatic test_gaps;
    test_frame("gaps_pattern", 8'b0100_1101, '0, 1'b0, 1'b1);
    test_frame("gaps_random", FL'($urandom), M'($urandom), 1'b1, 1'b1);
  endtask

  task automatic test_random;
    for (int i = 0; i < 6; i++) begin
      test_frame($sformatf("random%0d", i), FL'($urandom), M'($urandom), 1'b1, 1'($urandom));
    end
  endtask

  task automatic test_back_to_back;
    int lat, nv, extra;
    logic [FL-1:0] bits;
    logic rdy, hold;
`ifdef VITERBI_TB_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin failures++; $display("FAIL b2b_ovf_before got=%b exp=0", ovf); end
`endif
    gen_frame(FL'($urandom), M'($urandom), 1'b1);
    send_frame(1'b0);
    fork
      collect(lat, bits, nv, rdy, hold);
      begin
        for (int t = 0; t < FL; t++) begin
          dec_valid = 1'b1;
          dec       = dec_t'($urandom);
          best      = state_t'($urandom);
          @(negedge clk);
        end
        dec_valid = 1'b0;
      end
    join
    checks += 3;
    if (lat !== FL + 1) begin failures++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, FL + 1); end
    if (nv !== FL) begin failures++; $display("FAIL b2b_valid_len got=%0d exp=%0d", nv, FL); end
    if (bits !== frame_u) begin failures++; $display("FAIL b2b_bits got=%b exp=%b", bits, frame_u); end
    count_valid(3 * FL, extra);
    checks++;
    if (extra !== 0) begin failures++; $display("FAIL b2b_dropped_frame valid_cycles got=%0d exp=0", extra); end
`ifdef VITERBI_TB_OVF_EN
    checks++;
    if (ovf !== 1'b1) begin failures++; $display("FAIL b2b_ovf got=%b exp=1", ovf); end
`endif
    test_frame("b2b_next", FL'($urandom), M'($urandom), 1'b1, 1'b0);
  endtask

  task automatic test_reset_in_trace;
    int extra;
    gen_frame(FL'($urandom), M'($urandom), 1'b1);
    send_frame(1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checks += 4;
    if (ready !== 1'b1) begin failures++; $display("FAIL trace_rst_ready got=%b exp=1", ready); end
    if (valid !== 1'b0) begin failures++; $display("FAIL trace_rst_valid got=%b exp=0", valid); end
    if (busy !== 1'b0) begin failures++; $display("FAIL trace_rst_busy got=%b exp=0", busy); end
    if (bitv !== 1'b0) begin failures++; $display("FAIL trace_rst_bit got=%b exp=0", bitv); end
    #1 rst = 1'b0;
    count_valid(3 * FL, extra);
    checks++;
    if (extra !== 0) begin failures++; $display("FAIL trace_rst_no_output got=%0d exp=0", extra); end
    test_frame("trace_rst_next", FL'($urandom), M'($urandom), 1'b1, 1'b0);
  endtask

  task automatic test_reset_in_output;
    int c;
    gen_frame(FL'($urandom) | FL'(8), M'($urandom), 1'b1);
    send_frame(1'b0);
    c = 0;
    while (!valid && c < 100) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (valid !== 1'b1) begin failures++; $display("FAIL out_rst_wait got=%b exp=1 (timeout)", valid); end
    repeat (3) @(negedge clk);
    checks++;
    if (bitv !== frame_u[3]) begin failures++; $display("FAIL out_rst_bit3 got=%b exp=%b", bitv, frame_u[3]); end
    rst = 1'b1;
    #1;
    checks += 4;
    if (valid !== 1'b0) begin failures++; $display("FAIL out_rst_valid got=%b exp=0", valid); end
    if (ready !== 1'b1) begin failures++; $display("FAIL out_rst_ready got=%b exp=1", ready); end
    if (busy !== 1'b0) begin failures++; $display("FAIL out_rst_busy got=%b exp=0", busy); end
    if (bitv !== 1'b0) begin failures++; $display("FAIL out_rst_bit got=%b exp=0", bitv); end
    #1 rst = 1'b0;
    test_frame("out_rst_next", FL'($urandom), M'($urandom), 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_zero_frame();
    test_known_pattern();
    test_gaps();
    test_random();
    test_back_to_back();
    test_reset_in_trace();
    test_reset_in_output();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
